// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (P) vs. queued mul/div results (M).
// Optional starvation guard for queued M results is built when REGFILE_ARB_STARVE_EN is defined.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic [4:0]  p_dest,
    input  logic [31:0] p_data,
    output logic        p_stall,
    input  logic        m_valid,
    input  logic [4:0]  m_dest,
    input  logic [31:0] m_data,
    output logic        m_ready,
    output logic        rf_load,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_data,
    output logic        m_pending
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]       r_fifo_dest [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_alive;
    logic             r_rf_load;
    logic [4:0]       r_rf_dest;
    logic [31:0]      r_rf_data;

    logic             w_empty;
    logic             w_full;
    logic             w_enq;
    logic             w_hazard;
    logic             w_starve_hit;
    logic             w_grant_p;
    logic             w_drain;
    logic             w_stall;
    logic [DEPTH-1:0] w_occ;
    logic [4:0]       w_head_dest;
    logic [31:0]      w_head_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_head_dest = r_fifo_dest[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // r_alive keeps m_ready low while reset is held even though the count reads empty
    assign m_ready   = r_alive && !w_full;
    assign w_enq     = m_valid && m_ready;
    assign m_pending = !w_empty;
    assign p_stall   = w_stall;

    always_comb begin
        w_occ    = '0;
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
            if (w_occ[i] && (r_fifo_dest[i] == p_dest)) begin
                w_hazard = 1'b1;
            end
        end
        w_hazard = w_hazard && p_valid && (p_dest != 5'd0);
    end

    always_comb begin
        w_grant_p = 1'b0;
        w_drain   = 1'b0;
        w_stall   = 1'b0;
        if (w_empty) begin
            w_grant_p = p_valid;
        end else if (!p_valid) begin
            w_drain = 1'b1;
        end else if (w_hazard || w_starve_hit) begin
            w_stall = 1'b1;
            w_drain = 1'b1;
        end else begin
            w_grant_p = 1'b1;
        end
    end

`ifdef REGFILE_ARB_STARVE_EN
    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] r_starve;
    logic            w_case5;

    assign w_case5      = w_grant_p && !w_empty;
    assign w_starve_hit = (r_starve == SC_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_drain || w_empty) begin
            r_starve <= '0;
        end else if (w_case5 && !w_starve_hit) begin
            r_starve <= r_starve + SC_W'(1);
        end
    end
`else
    assign w_starve_hit = 1'b0;

    if (STARVE_LIMIT < 1) begin : g_starve_limit_invalid
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_alive  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy is tracked entirely by r_count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_dest[r_wr_ptr] <= m_dest;
            r_fifo_data[r_wr_ptr] <= m_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_load <= 1'b0;
            r_rf_dest <= 5'd0;
            r_rf_data <= 32'd0;
        end else begin
            r_rf_load <= 1'b0;
            if (w_grant_p && (p_dest != 5'd0)) begin
                r_rf_load <= 1'b1;
                r_rf_dest <= p_dest;
                r_rf_data <= p_data;
            end else if (w_drain && (w_head_dest != 5'd0)) begin
                r_rf_load <= 1'b1;
                r_rf_dest <= w_head_dest;
                r_rf_data <= w_head_data;
            end
        end
    end

    assign rf_load = r_rf_load;
    assign rf_dest = r_rf_dest;
    assign rf_data = r_rf_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table for single P writes,
// hand sequences for WAW, starvation, FIFO-full and mid-stream reset; scoreboard on rf_*.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        p_valid;
    logic [4:0]  p_dest;
    logic [31:0] p_data;
    logic        p_stall;
    logic        m_valid;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    logic        m_ready;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;
    logic        m_pending;

    int checks = 0;
    int errors = 0;

    logic [36:0] sb_q[$];

    typedef struct {
        logic        pv;
        logic [4:0]  pd;
        logic [31:0] data;
        logic        exp_stall;
        logic        exp_load;
    } vec_t;

    vec_t vecs[6];

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_valid   (p_valid),
        .p_dest    (p_dest),
        .p_data    (p_data),
        .p_stall   (p_stall),
        .m_valid   (m_valid),
        .m_dest    (m_dest),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .rf_load   (rf_load),
        .rf_dest   (rf_dest),
        .rf_data   (rf_data),
        .m_pending (m_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] d, input logic [31:0] v);
        sb_q.push_back({d, v});
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_load) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=x%0d:%h expected=no write", rf_dest, rf_data);
            end else begin
                chk("sb_write", {27'd0, rf_dest, rf_data}, {27'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  last_dest;
        logic [31:0] last_data;
        logic [31:0] pdata;
        logic        exp_st;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd9,  32'hCAFEF00D, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 5'd1,  32'h00000001, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 5'd0,  32'h0BADF00D, 1'b0, 1'b0};

        rst_n   = 1'b0;
        p_valid = 1'b0;
        p_dest  = 5'd0;
        p_data  = 32'd0;
        m_valid = 1'b0;
        m_dest  = 5'd0;
        m_data  = 32'd0;

        // reset state
        #12;
        chk("rst_m_ready", m_ready, 0);
        chk("rst_rf_load", rf_load, 0);
        chk("rst_rf_dest", rf_dest, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_m_pending", m_pending, 0);
        chk("rst_p_stall", p_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_m_ready", m_ready, 1);

        // single P writes with the FIFO empty
        last_dest = 5'd0;
        last_data = 32'd0;
        for (int i = 0; i < 6; i++) begin
            p_valid = vecs[i].pv;
            p_dest  = vecs[i].pd;
            p_data  = vecs[i].data;
            #1;
            chk("vec_stall", p_stall, vecs[i].exp_stall);
            if (vecs[i].exp_load) begin
                push_exp(vecs[i].pd, vecs[i].data);
                last_dest = vecs[i].pd;
                last_data = vecs[i].data;
            end
            step();
            chk("vec_load", rf_load, vecs[i].exp_load);
            chk("vec_dest", rf_dest, last_dest);
            chk("vec_data", rf_data, last_data);
        end
        p_valid = 1'b0;
        step();

        // WAW: M x7 queued, then P x7 must wait behind it
        m_valid = 1'b1; m_dest = 5'd7; m_data = 32'h11;
        #1;
        chk("waw_m_ready", m_ready, 1);
        step();
        m_valid = 1'b0;
        p_valid = 1'b1; p_dest = 5'd7; p_data = 32'h22;
        #1;
        chk("waw_stall", p_stall, 1);
        chk("waw_pending", m_pending, 1);
        push_exp(5'd7, 32'h11);
        step();
        #1;
        chk("waw_stall_clear", p_stall, 0);
        chk("waw_first_load", rf_load, 1);
        chk("waw_first_data", {rf_dest, rf_data}, {5'd7, 32'h11});
        push_exp(5'd7, 32'h22);
        step();
        p_valid = 1'b0;
        chk("waw_second_data", {rf_dest, rf_data}, {5'd7, 32'h22});
        step();
        step();

        // starvation: M x3 behind continuous P traffic to x9
        pdata = 32'h9000_0000;
        for (int k = 0; k < 8; k++) begin
            p_valid = 1'b1; p_dest = 5'd9; p_data = pdata;
            m_valid = (k == 0); m_dest = 5'd3; m_data = 32'h33;
            #1;
            exp_st = STARVE_EN && (k == 5);
            chk("starve_stall", p_stall, exp_st);
            if (exp_st) begin
                push_exp(5'd3, 32'h33);
            end else begin
                push_exp(5'd9, pdata);
                pdata = pdata + 32'd1;
            end
            step();
        end
        p_valid = 1'b0;
        m_valid = 1'b0;
        #1;
        chk("starve_pending", m_pending, !STARVE_EN);
        chk("starve_idle_stall", p_stall, 0);
        if (!STARVE_EN) push_exp(5'd3, 32'h33);
        step();
        chk("starve_drained", m_pending, 0);
        step();

        // FIFO full with P busy, then drains in order
        p_valid = 1'b1; p_dest = 5'd20; p_data = 32'hD0;
        m_valid = 1'b1; m_dest = 5'd10; m_data = 32'hA0;
        #1;
        chk("full_f0_ready", m_ready, 1);
        chk("full_f0_stall", p_stall, 0);
        push_exp(5'd20, 32'hD0);
        step();
        p_dest = 5'd21; p_data = 32'hD1;
        m_dest = 5'd11; m_data = 32'hB0;
        #1;
        chk("full_f1_ready", m_ready, 1);
        chk("full_f1_stall", p_stall, 0);
        push_exp(5'd21, 32'hD1);
        step();
        p_dest = 5'd22; p_data = 32'hD2;
        m_dest = 5'd12; m_data = 32'hC0;
        #1;
        chk("full_f2_ready", m_ready, 0);
        chk("full_f2_stall", p_stall, 0);
        push_exp(5'd22, 32'hD2);
        step();
        p_dest = 5'd23; p_data = 32'hD3;
        #1;
        chk("full_f3_ready", m_ready, 0);
        push_exp(5'd23, 32'hD3);
        step();
        p_valid = 1'b0;
        #1;
        chk("full_f4_ready", m_ready, 0);
        push_exp(5'd10, 32'hA0);
        step();
        #1;
        chk("full_f5_ready", m_ready, 1);
        push_exp(5'd11, 32'hB0);
        step();
        m_valid = 1'b0;
        #1;
        chk("full_f6_pending", m_pending, 1);
        push_exp(5'd12, 32'hC0);
        step();
        chk("full_f7_pending", m_pending, 0);
        step();
        step();

        // reset mid-stream with two entries queued
        p_valid = 1'b1; p_dest = 5'd25; p_data = 32'h250;
        m_valid = 1'b1; m_dest = 5'd13; m_data = 32'h130;
        push_exp(5'd25, 32'h250);
        step();
        p_dest = 5'd26; p_data = 32'h260;
        m_dest = 5'd14; m_data = 32'h140;
        push_exp(5'd26, 32'h260);
        step();
        p_dest = 5'd27; p_data = 32'h270;
        m_valid = 1'b0;
        #1;
        chk("mrst_pending_before", m_pending, 1);
        #6;
        rst_n = 1'b0;
        p_valid = 1'b0;
        #1;
        chk("mrst_rf_load", rf_load, 0);
        chk("mrst_pending", m_pending, 0);
        chk("mrst_m_ready", m_ready, 0);
        chk("mrst_p_stall", p_stall, 0);
        step();
        step();
        chk("mrst_hold_m_ready", m_ready, 0);
        chk("mrst_hold_rf_load", rf_load, 0);
        rst_n = 1'b1;
        step();
        chk("mrst_rel_m_ready", m_ready, 1);
        chk("mrst_rel_pending", m_pending, 0);
        chk("mrst_rel_rf_dest", rf_dest, 0);
        for (int i = 0; i < 4; i++) step();

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port between two writeback sources:
  - the in-order pipeline writeback stage (P);
  - the multi-cycle mul/div unit (M).
- P normally wins. M results wait in a small FIFO and drain on idle P cycles, on a write-after-write conflict, or on a starvation timeout.
- Sits between the MEM/WB stage and the register file's write port (load, dest, in). Outputs are registered.

## Interface

Parameters:
- DEPTH, 2 — M result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4 — consecutive P grants with M pending before P is forced to stall; ≥1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- p_valid  in  1  P writeback request this cycle
- p_dest  in  5  P destination register
- p_data  in  32  P write data
- p_stall  out  1  P not accepted this cycle; pipeline holds P inputs and does not advance (combinational)
- m_valid  in  1  M result valid
- m_dest  in  5  M destination register
- m_data  in  32  M result data
- m_ready  out  1  FIFO can accept; transfer on m_valid && m_ready
- rf_load  out  1  register file write enable (registered)
- rf_dest  out  5  register file write address (registered)
- rf_data  out  32  register file write data (registered)
- m_pending  out  1  FIFO non-empty

## Operation

State:
- FIFO: rd/wr pointers, count 0..DEPTH.
- Starvation counter: saturating, 0..STARVE_LIMIT.

m_ready:
- Equals count < DEPTH, computed from registered count.
- A dequeue in the same cycle does not raise m_ready.

Enqueue:
- A value enqueued in cycle t is eligible to drain no earlier than t+1. There is no same-cycle bypass.

Arbitration each cycle, first match wins:
1. FIFO empty: grant P if p_valid; p_stall=0.
2. FIFO non-empty, p_valid=0: drain FIFO head.
3. p_valid, p_dest≠0, and p_dest equals the dest of any occupied FIFO entry (WAW hazard): p_stall=1, drain head.
4. p_valid and starvation counter = STARVE_LIMIT (only with REGFILE_ARB_STARVE_EN): p_stall=1, drain head.
5. Otherwise: grant P; p_stall=0.

Starvation counter:
- Cleared when the head drains or the FIFO is empty.
- Incremented (saturating) on each case-5 grant.

Writes to x0:
- A grant whose dest=0 is consumed: P is accepted or the FIFO entry is popped.
- No rf_load is produced; rf_dest/rf_data keep their previous values.

Ordering:
- M entries drain in FIFO order.
- A P write to a register pending in M never reaches the register file before that M write.

## Timing

- Grant in cycle t → rf_load=1 with rf_dest/rf_data in cycle t+1, for exactly one cycle per write.
- Throughput: one write per cycle, sustained.
- p_stall and the arbitration decision are combinational from p_valid/p_dest and registered state.
- Reset (rst_n=0), asynchronous:
  - rf_load=0, rf_dest=0, rf_data=0; FIFO count=0, pointers=0, counter=0.
  - m_ready=0 while rst_n=0, and 1 from the first cycle after release.
  - m_pending=0, p_stall=0.
- Reset mid-operation discards FIFO contents and any write not yet presented on rf_*.
- FIFO full and m_valid=1: no enqueue; M holds its values.
- Full FIFO plus a drain in the same cycle: count decrements; m_ready rises the next cycle.
- Pointers wrap modulo DEPTH.

## Configuration

REGFILE_ARB_STARVE_EN:
- Defined: the starvation counter and arbitration case 4 are built.
  - Pending M results drain at least once per STARVE_LIMIT+1 cycles under continuous P traffic.
- Undefined: no counter is built and case 4 never fires.
  - M drains only on P-idle cycles or WAW conflicts.

## Test plan

- Reset behaviour. Assert rst_n=0 mid-stream with 2 entries queued. Required: rf_load=0 and m_pending=0 immediately; m_ready=0 during reset and 1 one cycle after release; no queued write ever appears.
- Basic P latency. FIFO empty; P writes x5=0xDEADBEEF at cycle t. Required: rf_load=1, rf_dest=5, rf_data=0xDEADBEEF at t+1; p_stall=0.
- WAW hazard and x0. M enqueues x7=0x11 at t; P presents x7=0x22 at t+1. Required:
  - p_stall=1 at t+1; rf_* shows x7=0x11 at t+2 and x7=0x22 at t+3.
  - Separately, a P write to x0 produces no rf_load.
- Starvation (STARVE_LIMIT=4, macro defined). M enqueues x3; P stays valid to x9 continuously. Required: four P grants, then p_stall=1 for exactly one cycle with x3 written; counter clears. With the macro undefined, x3 drains only after p_valid drops.
- FIFO full (DEPTH=2). Enqueue 2 M results with P busy to other registers. Required:
  - m_ready=0 while the FIFO is full; a third m_valid is held.
  - After P goes idle, the drains appear in order on consecutive cycles, and m_ready returns to 1 the cycle after the first drain.
